// File: rtl/canny_threshold_ctrl.sv
// canny_threshold_ctrl
//   Control stage in front of the double-threshold / hysteresis block.
//   - Classifies each NMS-suppressed gradient magnitude against the active
//     high/low thresholds into a 2-bit code (10 strong, 01 weak, 00 suppressed),
//     one registered cycle of latency, aligned with the delayed frame strobes.
//   - Host threshold updates arrive over a valid/ready handshake, sit in shadow
//     registers and are applied only on a vsync rising edge.
//   - Checks frame geometry (pixels per line, lines per frame) and reports a
//     per-frame status (frame_done pulse, size_err, strong pixel count).
//
// Ports
//   clk, rst_s                  clock, asynchronous active-low reset
//   cfg_valid/cfg_ready         host threshold update handshake
//   cfg_high, cfg_low           requested thresholds
//   cfg_err                     one-cycle pulse: update rejected (high < low)
//   pre_frame_vsync/href/clken  incoming frame, line and pixel strobes
//   grad_mag                    gradient magnitude for the current pixel
//   post_frame_vsync/href/clken strobes delayed by one cycle
//   max_g                       class code aligned with post_* strobes
//   act_high, act_low           thresholds in use this frame
//   frame_done                  one-cycle pulse after each completed frame
//   size_err                    geometry status of the last completed frame
//   strong_cnt                  strong pixels in the last completed frame
//
// Build option
//   CANNY_AUTO_THRESH_EN: when defined, the high threshold adapts by +/-4 at
//   the end of each frame (when no host update is pending) to keep the strong
//   pixel density between 1/64 and 1/16 of the frame.
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for a vsync rising edge; pixels classified, not counted
//   S_FRAME | inside a frame; counting pixels, lines and strong pixels
//   S_DONE  | single cycle: frame_done pulse, status published

module canny_threshold_ctrl #(
    parameter int                   MAG_WIDTH = 11,
    parameter int                   IMG_W     = 640,
    parameter int                   IMG_H     = 480,
    parameter logic [MAG_WIDTH-1:0] DEF_HIGH  = 11'd100,
    parameter logic [MAG_WIDTH-1:0] DEF_LOW   = 11'd40,
    parameter int                   CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst_s,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [MAG_WIDTH-1:0] cfg_high,
    input  logic [MAG_WIDTH-1:0] cfg_low,
    output logic                 cfg_err,
    input  logic                 pre_frame_vsync,
    input  logic                 pre_frame_href,
    input  logic                 pre_frame_clken,
    input  logic [MAG_WIDTH-1:0] grad_mag,
    output logic                 post_frame_vsync,
    output logic                 post_frame_href,
    output logic                 post_frame_clken,
    output logic [1:0]           max_g,
    output logic [MAG_WIDTH-1:0] act_high,
    output logic [MAG_WIDTH-1:0] act_low,
    output logic                 frame_done,
    output logic                 size_err,
    output logic [CNT_WIDTH-1:0] strong_cnt
);

    localparam logic [15:0] W_EXP = 16'(IMG_W);
    localparam logic [15:0] H_EXP = 16'(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // delayed strobes, edge detection
    logic vsync_q, href_q, clken_q;
    logic seen_low_q;
    logic vs_rise, vs_fall, hr_fall, pix_en;

    // classification
    logic                 is_strong, is_weak;
    logic [1:0]           class_d;
    logic [1:0]           max_g_q;

    // thresholds and host config
    logic [MAG_WIDTH-1:0] act_high_q, act_low_q;
    logic [MAG_WIDTH-1:0] shd_high_q, shd_low_q;
    logic                 pending_q;
    logic                 cfg_err_q;
    logic                 xfer, cfg_ok;

    // frame counters and status
    logic [15:0]          pix_cnt_q, line_cnt_q;
    logic [15:0]          pix_inc, line_inc, line_nxt;
    logic [CNT_WIDTH-1:0] strong_q, strong_inc, strong_nxt;
    logic                 err_q, err_nxt, pix_bad, strong_hit;
    logic                 size_err_q;
    logic [CNT_WIDTH-1:0] strong_cnt_q;

    // FSM control outputs
    logic frame_start, in_frame, frame_end, done_st;

    // A frame already running when reset releases must not be picked up, so a
    // rising edge only counts once vsync has been observed low after reset.
    assign vs_rise = pre_frame_vsync && !vsync_q && seen_low_q;
    assign vs_fall = !pre_frame_vsync && vsync_q;
    assign hr_fall = !pre_frame_href && href_q;
    assign pix_en  = pre_frame_href && pre_frame_clken;

    //----------------------------------------------------------------------
    // Strobe delay and classification
    //----------------------------------------------------------------------
    assign is_strong = (grad_mag >= act_high_q);
    assign is_weak   = (grad_mag >= act_low_q);

    always_comb begin
        class_d = 2'b00;
        if (is_strong) begin
            class_d = 2'b10;
        end else if (is_weak) begin
            class_d = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            clken_q    <= 1'b0;
            seen_low_q <= 1'b0;
            max_g_q    <= 2'b00;
        end else begin
            vsync_q    <= pre_frame_vsync;
            href_q     <= pre_frame_href;
            clken_q    <= pre_frame_clken;
            if (!pre_frame_vsync) begin
                seen_low_q <= 1'b1;
            end
            max_g_q    <= pre_frame_clken ? class_d : 2'b00;
        end
    end

    //----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    //----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (vs_rise) state_d = S_FRAME;
            S_FRAME: if (vs_fall) state_d = S_DONE;
            // a new frame may start right in the DONE cycle
            S_DONE:  state_d = vs_rise ? S_FRAME : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        in_frame    = 1'b0;
        frame_end   = 1'b0;
        done_st     = 1'b0;
        case (state_q)
            S_IDLE: begin
                frame_start = vs_rise;
            end
            S_FRAME: begin
                in_frame  = 1'b1;
                frame_end = vs_fall;
            end
            S_DONE: begin
                done_st     = 1'b1;
                frame_start = vs_rise;
            end
            default: begin
                frame_start = 1'b0;
            end
        endcase
    end

    //----------------------------------------------------------------------
    // Geometry and strong-pixel counters (all saturating)
    //----------------------------------------------------------------------
    always_comb begin
        pix_inc    = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
        line_inc   = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;
        line_nxt   = hr_fall ? line_inc : line_cnt_q;
        pix_bad    = hr_fall && (pix_cnt_q != W_EXP);
        strong_hit = pre_frame_clken && is_strong;
        strong_inc = (strong_q == {CNT_WIDTH{1'b1}}) ? strong_q
                                                     : strong_q + CNT_WIDTH'(1);
        strong_nxt = strong_hit ? strong_inc : strong_q;
        // a line ending in the same cycle as the frame still gets counted
        err_nxt    = err_q || pix_bad || (frame_end && (line_nxt != H_EXP));
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            pix_cnt_q  <= 16'd0;
            line_cnt_q <= 16'd0;
            strong_q   <= '0;
            err_q      <= 1'b0;
        end else if (frame_start) begin
            pix_cnt_q  <= 16'd0;
            line_cnt_q <= 16'd0;
            strong_q   <= '0;
            err_q      <= 1'b0;
        end else if (in_frame) begin
            if (hr_fall) begin
                pix_cnt_q <= 16'd0;
            end else if (pix_en) begin
                pix_cnt_q <= pix_inc;
            end
            line_cnt_q <= line_nxt;
            strong_q   <= strong_nxt;
            err_q      <= err_nxt;
        end
    end

    // Status is captured on entry to DONE so it is already valid while
    // frame_done is high.
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            size_err_q   <= 1'b0;
            strong_cnt_q <= '0;
        end else if (frame_end) begin
            size_err_q   <= err_nxt;
            strong_cnt_q <= strong_nxt;
        end
    end

    //----------------------------------------------------------------------
    // Optional end-of-frame high threshold adaptation
    //----------------------------------------------------------------------
`ifdef CANNY_AUTO_THRESH_EN
    localparam logic [CNT_WIDTH-1:0] HI_LIM = CNT_WIDTH'(IMG_W * IMG_H / 16);
    localparam logic [CNT_WIDTH-1:0] LO_LIM = CNT_WIDTH'(IMG_W * IMG_H / 64);

    logic [MAG_WIDTH:0]   up_w, low_plus4_w;
    logic [MAG_WIDTH-1:0] auto_high;
    logic                 auto_chg;

    always_comb begin
        up_w        = {1'b0, act_high_q} + (MAG_WIDTH + 1)'(4);
        low_plus4_w = {1'b0, act_low_q} + (MAG_WIDTH + 1)'(4);
        auto_high   = act_high_q;
        auto_chg    = 1'b0;
        if (strong_cnt_q > HI_LIM) begin
            auto_chg  = 1'b1;
            auto_high = up_w[MAG_WIDTH] ? {MAG_WIDTH{1'b1}} : up_w[MAG_WIDTH-1:0];
        end else if (strong_cnt_q < LO_LIM) begin
            auto_chg  = 1'b1;
            // never step below the low threshold
            auto_high = ({1'b0, act_high_q} < low_plus4_w)
                        ? act_low_q : act_high_q - MAG_WIDTH'(4);
        end
    end
`endif

    //----------------------------------------------------------------------
    // Host config handshake and frame-boundary apply
    //----------------------------------------------------------------------
    assign cfg_ready = !pending_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_high >= cfg_low);

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            act_high_q <= DEF_HIGH;
            act_low_q  <= DEF_LOW;
            shd_high_q <= DEF_HIGH;
            shd_low_q  <= DEF_LOW;
            pending_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= xfer && !cfg_ok;
            // xfer needs !pending_q, so the apply and load below never collide;
            // a transfer in the rising-edge cycle therefore waits a frame.
            if (vs_rise && pending_q) begin
                act_high_q <= shd_high_q;
                act_low_q  <= shd_low_q;
                pending_q  <= 1'b0;
            end
`ifdef CANNY_AUTO_THRESH_EN
            else if (done_st && !pending_q && auto_chg) begin
                act_high_q <= auto_high;
            end
`endif
            if (xfer && cfg_ok) begin
                shd_high_q <= cfg_high;
                shd_low_q  <= cfg_low;
                pending_q  <= 1'b1;
            end
        end
    end

    //----------------------------------------------------------------------
    // Outputs
    //----------------------------------------------------------------------
    assign cfg_err          = cfg_err_q;
    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_frame_clken = clken_q;
    assign max_g            = max_g_q;
    assign act_high         = act_high_q;
    assign act_low          = act_low_q;
    assign frame_done       = done_st;
    assign size_err         = size_err_q;
    assign strong_cnt       = strong_cnt_q;

endmodule

// File: tb/tb_canny_threshold_ctrl.sv
// Directed bench for canny_threshold_ctrl, run with a reduced 16x12 frame.
module tb_canny_threshold_ctrl;

    localparam int W = 16;
    localparam int H = 12;

    logic        clk = 1'b0;
    logic        rst_s = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [10:0] cfg_high = '0;
    logic [10:0] cfg_low = '0;
    logic        cfg_err;
    logic        pre_frame_vsync = 1'b0;
    logic        pre_frame_href = 1'b0;
    logic        pre_frame_clken = 1'b0;
    logic [10:0] grad_mag = '0;
    logic        post_frame_vsync, post_frame_href, post_frame_clken;
    logic [1:0]  max_g;
    logic [10:0] act_high, act_low;
    logic        frame_done, size_err;
    logic [19:0] strong_cnt;

    canny_threshold_ctrl #(
        .MAG_WIDTH(11), .IMG_W(W), .IMG_H(H),
        .DEF_HIGH(11'd100), .DEF_LOW(11'd40), .CNT_WIDTH(20)
    ) dut (
        .clk(clk), .rst_s(rst_s),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_err(cfg_err),
        .pre_frame_vsync(pre_frame_vsync), .pre_frame_href(pre_frame_href),
        .pre_frame_clken(pre_frame_clken), .grad_mag(grad_mag),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .max_g(max_g),
        .act_high(act_high), .act_low(act_low),
        .frame_done(frame_done), .size_err(size_err), .strong_cnt(strong_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-run observations
    int          mg_bad, done_cnt, err_cnt, rdy_low;
    logic        last_size_err;
    logic [19:0] last_strong;
    bit          mg_en = 1'b0;

    // bench model state
    logic [10:0] exp_h = 11'd100;
    logic [10:0] exp_l = 11'd40;
    logic [1:0]  exp_mg = 2'b00;
    logic        prev_v = 1'b0, prev_h = 1'b0, prev_c = 1'b0;
    bit          cfg_req = 1'b0;
    logic [10:0] cfg_h_req = '0, cfg_l_req = '0;

    function automatic logic [1:0] cls(input logic [10:0] m);
        if (m >= exp_h) return 2'b10;
        if (m >= exp_l) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [10:0] pat(input int i);
        case (i % 4)
            0:       return 11'd100;
            1:       return 11'd99;
            2:       return 11'd40;
            default: return 11'd39;
        endcase
    endfunction

    // Drive one cycle of stimulus just after the rising edge, then observe
    // on the falling edge the outputs produced from the previous cycle.
    task automatic drive_cycle(input logic v, input logic h, input logic c,
                               input logic [10:0] m);
        @(posedge clk);
        #1;
        pre_frame_vsync = v;
        pre_frame_href  = h;
        pre_frame_clken = c;
        grad_mag        = m;
        cfg_valid       = cfg_req;
        cfg_high        = cfg_h_req;
        cfg_low         = cfg_l_req;
        cfg_req         = 1'b0;
        @(negedge clk);
        if (mg_en) begin
            if (max_g !== exp_mg || post_frame_vsync !== prev_v ||
                post_frame_href !== prev_h || post_frame_clken !== prev_c) begin
                if (mg_bad == 0)
                    $display("  first stream mismatch at %0t: max_g=%b want %b", $time, max_g, exp_mg);
                mg_bad++;
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            last_size_err = size_err;
            last_strong   = strong_cnt;
        end
        if (cfg_err === 1'b1) err_cnt++;
        if (cfg_ready === 1'b0) rdy_low++;
        exp_mg = c ? cls(m) : 2'b00;
        prev_v = v;
        prev_h = h;
        prev_c = c;
    endtask

    // cfg_at: -1 none, -2 in the vsync rising cycle, k>=0 at first pixel of line k
    task automatic run_frame(input int nlines, input int short_line, input int cfg_at);
        int pidx;
        int n;
        mg_bad = 0; done_cnt = 0; err_cnt = 0; rdy_low = 0;
        last_size_err = 1'bx;
        last_strong   = 'x;
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        if (cfg_at == -2) cfg_req = 1'b1;
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 0, 0, 0);
        pidx = 0;
        for (int l = 0; l < nlines; l++) begin
            n = (l == short_line) ? W - 1 : W;
            for (int p = 0; p < n; p++) begin
                if (cfg_at == l && p == 0) cfg_req = 1'b1;
                drive_cycle(1, 1, 1, pat(pidx));
                pidx++;
            end
            drive_cycle(1, 0, 0, 0);
            drive_cycle(1, 0, 0, 0);
        end
        drive_cycle(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive_cycle(0, 0, 0, 0);
    endtask

    task automatic test_reset;
        rst_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (max_g !== 2'b00) begin errors++; $display("FAIL reset_max_g: got %b want 00", max_g); end
        checks++; if (act_high !== 11'd100) begin errors++; $display("FAIL reset_act_high: got %0d want 100", act_high); end
        checks++; if (act_low !== 11'd40) begin errors++; $display("FAIL reset_act_low: got %0d want 40", act_low); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        checks++; if (cfg_err !== 1'b0 || frame_done !== 1'b0 || size_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: err=%b done=%b size=%b want 000", cfg_err, frame_done, size_err); end
        checks++; if (strong_cnt !== 20'd0) begin errors++; $display("FAIL reset_strong_cnt: got %0d want 0", strong_cnt); end
        checks++; if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000) begin
            errors++; $display("FAIL reset_post: got %b want 000", {post_frame_vsync, post_frame_href, post_frame_clken}); end
        rst_s = 1'b1;
        exp_mg = 2'b00; prev_v = 0; prev_h = 0; prev_c = 0;
        mg_en = 1'b1;
    endtask

    task automatic test_basic_frame;
        exp_h = 11'd100; exp_l = 11'd40;
        run_frame(H, -1, -1);
        checks++; if (mg_bad !== 0) begin errors++; $display("FAIL basic_max_g: %0d bad cycles want 0", mg_bad); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_frame_done: %0d pulses want 1", done_cnt); end
        checks++; if (last_size_err !== 1'b0) begin errors++; $display("FAIL basic_size_err: got %b want 0", last_size_err); end
        checks++; if (last_strong !== 20'd48) begin errors++; $display("FAIL basic_strong_cnt: got %0d want 48", last_strong); end
    endtask

    task automatic test_cfg_update;
        exp_h = 11'd100; exp_l = 11'd40;
        cfg_h_req = 11'd200; cfg_l_req = 11'd50;
        run_frame(H, -1, 3);
        checks++; if (mg_bad !== 0) begin errors++; $display("FAIL cfg_mid_max_g: %0d bad cycles want 0", mg_bad); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_mid_ready: got %b want 0", cfg_ready); end
        checks++; if (act_high !== 11'd100 || act_low !== 11'd40) begin
            errors++; $display("FAIL cfg_mid_act: got %0d/%0d want 100/40", act_high, act_low); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL cfg_mid_err: %0d pulses want 0", err_cnt); end
        checks++; if (last_strong !== 20'd48) begin errors++; $display("FAIL cfg_mid_strong: got %0d want 48", last_strong); end
        exp_h = 11'd200; exp_l = 11'd50;
        run_frame(H, -1, -1);
        checks++; if (act_high !== 11'd200 || act_low !== 11'd50) begin
            errors++; $display("FAIL cfg_apply_act: got %0d/%0d want 200/50", act_high, act_low); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_apply_ready: got %b want 1", cfg_ready); end
        checks++; if (mg_bad !== 0) begin errors++; $display("FAIL cfg_apply_max_g: %0d bad cycles want 0", mg_bad); end
        checks++; if (last_strong !== 20'd0 || done_cnt !== 1) begin
            errors++; $display("FAIL cfg_apply_strong: got %0d (done %0d) want 0 (done 1)", last_strong, done_cnt); end
    endtask

    task automatic test_cfg_reject;
        err_cnt = 0; rdy_low = 0;
        cfg_h_req = 11'd30; cfg_l_req = 11'd60;
        cfg_req = 1'b1;
        for (int k = 0; k < 5; k++) drive_cycle(0, 0, 0, 0);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL reject_cfg_err: %0d pulses want 1", err_cnt); end
        checks++; if (rdy_low !== 0) begin errors++; $display("FAIL reject_cfg_ready: low %0d cycles want 0", rdy_low); end
        checks++; if (act_high !== 11'd200 || act_low !== 11'd50) begin
            errors++; $display("FAIL reject_act: got %0d/%0d want 200/50", act_high, act_low); end
    endtask

    task automatic test_cfg_at_vsync_rise;
        exp_h = 11'd200; exp_l = 11'd50;
        cfg_h_req = 11'd100; cfg_l_req = 11'd40;
        run_frame(H, -1, -2);
        checks++; if (act_high !== 11'd200 || act_low !== 11'd50) begin
            errors++; $display("FAIL rise_hold_act: got %0d/%0d want 200/50", act_high, act_low); end
        checks++; if (mg_bad !== 0 || last_strong !== 20'd0) begin
            errors++; $display("FAIL rise_hold_class: bad %0d strong %0d want 0/0", mg_bad, last_strong); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rise_hold_ready: got %b want 0", cfg_ready); end
        exp_h = 11'd100; exp_l = 11'd40;
        run_frame(H, -1, -1);
        checks++; if (act_high !== 11'd100 || act_low !== 11'd40) begin
            errors++; $display("FAIL rise_apply_act: got %0d/%0d want 100/40", act_high, act_low); end
        checks++; if (last_strong !== 20'd48 || mg_bad !== 0) begin
            errors++; $display("FAIL rise_apply_class: strong %0d bad %0d want 48/0", last_strong, mg_bad); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rise_apply_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_size_err;
        exp_h = 11'd100; exp_l = 11'd40;
        run_frame(H, 10, -1);
        checks++; if (done_cnt !== 1 || last_size_err !== 1'b1) begin
            errors++; $display("FAIL size_short_line: done %0d size_err %b want 1/1", done_cnt, last_size_err); end
        checks++; if (last_strong !== 20'd48) begin errors++; $display("FAIL size_short_line_strong: got %0d want 48", last_strong); end
        run_frame(H - 1, -1, -1);
        checks++; if (done_cnt !== 1 || last_size_err !== 1'b1) begin
            errors++; $display("FAIL size_short_frame: done %0d size_err %b want 1/1", done_cnt, last_size_err); end
        checks++; if (last_strong !== 20'd44) begin errors++; $display("FAIL size_short_frame_strong: got %0d want 44", last_strong); end
        run_frame(H, -1, -1);
        checks++; if (done_cnt !== 1 || last_size_err !== 1'b0) begin
            errors++; $display("FAIL size_recover: done %0d size_err %b want 1/0", done_cnt, last_size_err); end
        checks++; if (mg_bad !== 0) begin errors++; $display("FAIL size_max_g: %0d bad cycles want 0", mg_bad); end
    endtask

    task automatic test_reset_mid_frame;
        int pidx;
        mg_bad = 0; done_cnt = 0;
        cfg_h_req = 11'd200; cfg_l_req = 11'd50;
        cfg_req = 1'b1;
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0);
        exp_h = 11'd200; exp_l = 11'd50;
        drive_cycle(1, 0, 0, 0);
        pidx = 0;
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < W; p++) begin
                drive_cycle(1, 1, 1, pat(pidx));
                pidx++;
            end
            drive_cycle(1, 0, 0, 0);
        end
        checks++; if (act_high !== 11'd200 || mg_bad !== 0) begin
            errors++; $display("FAIL rstmid_pre_act: act_high %0d bad %0d want 200/0", act_high, mg_bad); end
        mg_en = 1'b0;
        rst_s = 1'b0;
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 0, 0, 0);
        rst_s = 1'b1;
        checks++; if (act_high !== 11'd100 || act_low !== 11'd40) begin
            errors++; $display("FAIL rstmid_act: got %0d/%0d want 100/40", act_high, act_low); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", cfg_ready); end
        exp_h = 11'd100; exp_l = 11'd40;
        drive_cycle(1, 0, 0, 0);
        mg_bad = 0; done_cnt = 0;
        mg_en = 1'b1;
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < W; p++) begin
                drive_cycle(1, 1, 1, pat(pidx));
                pidx++;
            end
            drive_cycle(1, 0, 0, 0);
        end
        drive_cycle(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive_cycle(0, 0, 0, 0);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done: %0d pulses want 0", done_cnt); end
        checks++; if (mg_bad !== 0) begin errors++; $display("FAIL rstmid_class: %0d bad cycles want 0", mg_bad); end
        run_frame(H, -1, -1);
        checks++; if (done_cnt !== 1 || last_size_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_next_frame: done %0d size_err %b want 1/0", done_cnt, last_size_err); end
        checks++; if (last_strong !== 20'd48) begin errors++; $display("FAIL rstmid_next_strong: got %0d want 48", last_strong); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_cfg_update();
        test_cfg_reject();
        test_cfg_at_vsync_rise();
        test_size_err();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

endmodule
